// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: default widths, flag register type and buffered entry type for exec_result_stage (entry gains a parity bit under EXEC_RESULT_PARITY_EN)
package exec_stage_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int RD_BITS_DEF = 5;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
  typedef struct packed {
    logic [WIDTH_DEF-1:0] result;
    logic [RD_BITS_DEF-1:0] rd;
    logic reg_write;
`ifdef EXEC_RESULT_PARITY_EN
    logic parity;
`endif
  } result_entry_t;
endpackage

// File: rtl/flag_calc.sv
// flag_calc: combinational N/Z/C/V candidate from result (WIDTH), carry and overflow inputs; flags output
module flag_calc
  import exec_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  output flags_t           flags
);
  always_comb begin
    flags.n = result[WIDTH-1];
    flags.z = result == '0;
    flags.c = carry;
    flags.v = overflow;
  end
endmodule

// File: rtl/exec_result_stage.sv
// exec_result_stage: 2-entry skid FIFO between ALU and writeback with NZCV flag register; ports clk, reset (sync active-low), flush, in_* valid/ready/result/carry/overflow/set_flags/rd/reg_write, out_* valid/ready/result/rd/reg_write, flag_n/z/c/v, out_parity when EXEC_RESULT_PARITY_EN is defined
module exec_result_stage
  import exec_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RD_BITS = RD_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_result,
  input  logic               in_carry,
  input  logic               in_overflow,
  input  logic               in_set_flags,
  input  logic [RD_BITS-1:0] in_rd,
  input  logic               in_reg_write,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [RD_BITS-1:0] out_rd,
  output logic               out_reg_write,
`ifdef EXEC_RESULT_PARITY_EN
  output logic               out_parity,
`endif
  output logic               flag_n,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v
);
  result_entry_t mem_q [2];
  result_entry_t mem_d [2];
  result_entry_t in_entry, head;
  logic [1:0] count_q, count_d;
  logic wr_q, wr_d, rd_q, rd_d, push, pop;
  flags_t flags_q, flags_d, flags_new;
  flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
    .result(in_result),
    .carry(in_carry),
    .overflow(in_overflow),
    .flags(flags_new)
  );
  always_comb begin
    in_entry = '0;
    in_entry.result = WIDTH_DEF'(in_result);
    in_entry.rd = RD_BITS_DEF'(in_rd);
    in_entry.reg_write = in_reg_write;
`ifdef EXEC_RESULT_PARITY_EN
    in_entry.parity = ^in_result;
`endif
    in_ready = reset && count_q != 2'd2;
    out_valid = count_q != 2'd0;
    push = in_valid && in_ready && !flush;
    pop = out_valid && out_ready && !flush;
    head = out_valid ? mem_q[rd_q] : '0;
    mem_d[0] = push && !wr_q ? in_entry : mem_q[0];
    mem_d[1] = push && wr_q ? in_entry : mem_q[1];
    wr_d = flush ? 1'b0 : wr_q ^ push;
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    flags_d = push && in_set_flags ? flags_new : flags_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      count_q <= 2'd0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      flags_q <= '0;
    end else begin
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      flags_q <= flags_d;
    end
  end
  assign out_result = WIDTH'(head.result);
  assign out_rd = RD_BITS'(head.rd);
  assign out_reg_write = head.reg_write;
`ifdef EXEC_RESULT_PARITY_EN
  assign out_parity = head.parity;
`endif
  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;
endmodule

// File: tb/tb_exec_result_stage.sv
// tb_exec_result_stage: directed scenarios plus randomized run against a queue-based reference model
module tb_exec_result_stage;
  localparam int W = 64;
  localparam int R = 5;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, in_carry = 0, in_overflow = 0;
  logic in_set_flags = 0, in_reg_write = 0, out_ready = 0;
  logic [W-1:0] in_result = '0;
  logic [R-1:0] in_rd = '0;
  logic in_ready, out_valid, out_reg_write, flag_n, flag_z, flag_c, flag_v;
  logic [W-1:0] out_result;
  logic [R-1:0] out_rd;
`ifdef EXEC_RESULT_PARITY_EN
  logic out_parity;
`endif
  int tests = 0, fails = 0;
  typedef struct {
    logic [W-1:0] res;
    logic [R-1:0] rd;
    logic rw;
  } ent_t;
  ent_t q[$];
  logic [3:0] mflags = 4'b0;
  always #5 clk = ~clk;
  exec_result_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_overflow(in_overflow), .in_set_flags(in_set_flags),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
`ifdef EXEC_RESULT_PARITY_EN
    .out_parity(out_parity),
`endif
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );
  task automatic tick();
    bit push, pop;
    ent_t e;
    push = reset && in_valid && q.size() < 2 && !flush;
    pop = q.size() > 0 && out_ready && !flush;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      mflags = 4'b0;
    end else if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.res = in_result;
        e.rd = in_rd;
        e.rw = in_reg_write;
        q.push_back(e);
        if (in_set_flags) mflags = {in_result[W-1], in_result == '0, in_carry, in_overflow};
      end
    end
    #1;
  endtask
  task automatic drive(input logic v, input logic [W-1:0] r, input logic sf, input logic c, input logic o);
    in_valid = v;
    in_result = r;
    in_set_flags = sf;
    in_carry = c;
    in_overflow = o;
    in_rd = R'($urandom);
    in_reg_write = 1'($urandom);
  endtask
  task automatic test_reset();
    reset = 0;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {flag_n, flag_z, flag_c, flag_v}); end
    tests++; if (out_result !== '0) begin fails++; $display("FAIL reset_result got=%0h exp=0", out_result); end
    reset = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready); end
  endtask
  task automatic test_basic();
    logic [R-1:0] rd;
    out_ready = 1;
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1);
    tick();
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1011) begin fails++; $display("FAIL basic_flags_pre got=%b exp=1011", {flag_n, flag_z, flag_c, flag_v}); end
    drive(1, 64'h1010_1010_1010_1010, 1, 0, 0);
    in_rd = 5'd3;
    in_reg_write = 1;
    rd = in_rd;
    tick();
    in_valid = 0;
    #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    tests++; if (out_result !== 64'h1010_1010_1010_1010) begin fails++; $display("FAIL basic_result got=%0h exp=1010101010101010", out_result); end
    tests++; if (out_rd !== rd || out_reg_write !== 1'b1) begin fails++; $display("FAIL basic_rd got=%0h/%0b exp=%0h/1", out_rd, out_reg_write, rd); end
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin fails++; $display("FAIL basic_flags got=%b exp=0000", {flag_n, flag_z, flag_c, flag_v}); end
    tick();
    tests++; if (out_valid !== 1'b0 || out_result !== '0 || out_rd !== '0 || out_reg_write !== 1'b0) begin fails++; $display("FAIL basic_empty got=%0b/%0h/%0h/%0b exp=0/0/0/0", out_valid, out_result, out_rd, out_reg_write); end
  endtask
  task automatic test_flags_hold();
    out_ready = 1;
    drive(1, 64'h0, 1, 0, 0);
    tick();
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0100) begin fails++; $display("FAIL hold_zero got=%b exp=0100", {flag_n, flag_z, flag_c, flag_v}); end
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1);
    tick();
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0100) begin fails++; $display("FAIL hold_noset got=%b exp=0100", {flag_n, flag_z, flag_c, flag_v}); end
    drive(0, 64'h8000_0000_0000_0000, 1, 1, 1);
    tick();
    tick();
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0100) begin fails++; $display("FAIL hold_idle got=%b exp=0100", {flag_n, flag_z, flag_c, flag_v}); end
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] a, b, c;
    logic [W-1:0] got [3];
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    out_ready = 0;
    drive(1, a, 0, 0, 0);
    tick();
    drive(1, b, 0, 0, 0);
    tick();
    drive(1, c, 0, 0, 0);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full got=%0b exp=0", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_result !== a || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_held got=%0b/%0h/%0b exp=1/%0h/0", out_valid, out_result, in_ready, a); end
    out_ready = 1;
    #1;
    got[0] = out_result;
    tick();
    got[1] = out_result;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_pop got=%0b exp=1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    got[2] = out_result;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_c_valid got=%0b exp=1", out_valid); end
    tick();
    tests++; if (got[0] !== a || got[1] !== b || got[2] !== c) begin fails++; $display("FAIL b2b_order got=%0h,%0h,%0h exp=%0h,%0h,%0h", got[0], got[1], got[2], a, b, c); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained got=%0b exp=0", out_valid); end
  endtask
  task automatic test_simultaneous();
    logic [W-1:0] v [11];
    int bad = 0;
    for (int i = 0; i < 11; i++) v[i] = {$urandom, $urandom};
    out_ready = 0;
    drive(1, v[0], 0, 0, 0);
    tick();
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      drive(1, v[i], 0, 0, 0);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== v[i-1]) begin
        bad++;
        $display("FAIL simul_step%0d got=%0b/%0b/%0h exp=1/1/%0h", i, out_valid, in_ready, out_result, v[i-1]);
      end
      tick();
    end
    in_valid = 0;
    tests++; if (bad != 0) fails++;
    tests++; if (out_valid !== 1'b1 || out_result !== v[10]) begin fails++; $display("FAIL simul_last got=%0b/%0h exp=1/%0h", out_valid, out_result, v[10]); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL simul_drained got=%0b exp=0", out_valid); end
  endtask
  task automatic test_flush();
    out_ready = 0;
    drive(1, 64'h0, 1, 0, 0);
    tick();
    drive(1, 64'h1234, 0, 0, 0);
    tick();
    flush = 1;
    drive(1, 64'h8000_0000_0000_0000, 1, 1, 1);
    tick();
    flush = 0;
    in_valid = 0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_full_valid got=%0b exp=0", out_valid); end
    tests++; if (flag_z !== 1'b1 || flag_n !== 1'b0) begin fails++; $display("FAIL flush_full_flags got=z%0b/n%0b exp=z1/n0", flag_z, flag_n); end
    drive(1, 64'h55, 0, 0, 0);
    tick();
    out_ready = 1;
    flush = 1;
    drive(1, 64'h8000_0000_0000_0000, 1, 1, 1);
    tick();
    flush = 0;
    in_valid = 0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_one got=%0b/%0b exp=0/1", out_valid, in_ready); end
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0100) begin fails++; $display("FAIL flush_one_flags got=%b exp=0100", {flag_n, flag_z, flag_c, flag_v}); end
  endtask
  task automatic test_reset_mid();
    int pulses = 0;
    out_ready = 0;
    drive(1, 64'h8000_0000_0000_0000, 1, 1, 0);
    tick();
    drive(1, 64'h77, 0, 0, 0);
    tick();
    in_valid = 0;
    reset = 0;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_during got=%0b/%0b exp=0/0", out_valid, in_ready); end
    tests++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0) begin fails++; $display("FAIL rstmid_flags got=%b exp=0000", {flag_n, flag_z, flag_c, flag_v}); end
    reset = 1;
    out_ready = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%0b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
  endtask
  task automatic test_random();
    int bad = 0;
    logic [W-1:0] r;
    logic [W-1:0] er;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: r = '0;
        1: r = {1'b1, 63'($urandom)};
        default: r = {$urandom, $urandom};
      endcase
      drive(1'($urandom_range(3) != 0), r, 1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = $urandom_range(2) != 0;
      flush = $urandom_range(19) == 0;
      reset = $urandom_range(39) != 0;
      #1;
      er = q.size() > 0 ? q[0].res : '0;
      if (in_ready !== (reset && q.size() < 2) || out_valid !== (q.size() > 0) || out_result !== er) begin
        bad++;
        $display("FAIL rand_out%0d got=%0b/%0b/%0h exp=%0b/%0b/%0h", i, in_ready, out_valid, out_result, reset && q.size() < 2, q.size() > 0, er);
      end
      if (q.size() > 0 && (out_rd !== q[0].rd || out_reg_write !== q[0].rw)) begin
        bad++;
        $display("FAIL rand_fields%0d got=%0h/%0b exp=%0h/%0b", i, out_rd, out_reg_write, q[0].rd, q[0].rw);
      end
`ifdef EXEC_RESULT_PARITY_EN
      if (out_parity !== (q.size() > 0 ? ^q[0].res : 1'b0)) begin
        bad++;
        $display("FAIL rand_parity%0d got=%0b", i, out_parity);
      end
`endif
      if ({flag_n, flag_z, flag_c, flag_v} !== mflags) begin
        bad++;
        $display("FAIL rand_flags%0d got=%b exp=%b", i, {flag_n, flag_z, flag_c, flag_v}, mflags);
      end
      tick();
    end
    reset = 1;
    flush = 0;
    in_valid = 0;
    tests++; if (bad != 0) fails++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_flags_hold();
    test_back_to_back();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exec_result_stage.md
EXEC_RESULT_STAGE -- requirements
Module: exec_result_stage

Interface
REQ-001 Parameter WIDTH, default 64: datapath width of the ALU result.
REQ-002 Parameter RD_BITS, default 5: destination register index width.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 flush  input  1: synchronous discard of all buffered entries.
REQ-006 in_valid  input  1: ALU result presented.
REQ-007 in_ready  output  1: stage can accept the presented result.
REQ-008 in_result  input  WIDTH: ALU result, e.g. the bitwise XOR output.
REQ-009 in_carry, in_overflow  input  1 each: adder carry-out and signed overflow.
REQ-010 in_set_flags  input  1: instruction updates the flags (ADDS/SUBS class).
REQ-011 in_rd  input  RD_BITS: destination register.
REQ-012 in_reg_write  input  1: result is written back.
REQ-013 out_valid  output  1: head entry available.
REQ-014 out_ready  input  1: writeback consumes head.
REQ-015 out_result  output  WIDTH; out_rd  output  RD_BITS; out_reg_write  output  1: head entry fields.
REQ-016 flag_n, flag_z, flag_c, flag_v  output  1 each: architectural flag register.

Function
REQ-017 Buffer SHALL be a 2-entry FIFO (skid buffer); push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready SHALL be 1 when occupancy < 2, combinationally independent of out_ready.
REQ-019 Entry accepted at edge k SHALL appear on out_valid/out_* immediately after edge k (latency 1 cycle).
REQ-020 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, with the new entry at the head after the edge.
REQ-021 Read/write pointers SHALL wrap modulo 2; order SHALL be strictly FIFO.
REQ-022 With occupancy 0, out_valid SHALL be 0 and out_result/out_rd/out_reg_write SHALL be 0.
REQ-023 On a push with in_set_flags=1, flags SHALL update at the same edge: Z = (in_result == 0), N = in_result[WIDTH-1], C = in_carry, V = in_overflow.
REQ-024 Flags SHALL hold their value on pushes with in_set_flags=0 and on cycles without a push.
REQ-025 flush=1 SHALL set occupancy to 0 at the edge and suppress any simultaneous push or pop; flags SHALL be unchanged, and a same-cycle set-flags push SHALL NOT update them.

Reset
REQ-026 reset=0 SHALL clear occupancy, pointers, out_valid and the flags (N=Z=C=V=0) at the edge, overriding flush and push.
REQ-027 in_ready SHALL be 0 while reset=0, and 1 in the first cycle after release.
REQ-028 Reset asserted mid-transfer SHALL discard the buffered entries without producing any out_valid pulse for them.

Configuration
REQ-029 Macro EXEC_RESULT_PARITY_EN: when defined, each entry SHALL store even parity of in_result, driven on an added output out_parity (1 bit; 0 when empty).
REQ-030 Without EXEC_RESULT_PARITY_EN, neither the port nor the parity storage SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-031 Package exec_stage_pkg SHALL hold the WIDTH/RD_BITS defaults, typedef flags_t (n, z, c, v) and typedef result_entry_t (result, rd, reg_write, optional parity).
REQ-032 Combinational sub-module flag_calc SHALL compute the N/Z/C/V candidate from in_result, in_carry and in_overflow.

Verification
REQ-033 Push 64'h1010101010101010 with set_flags=1, carry=0, ovf=0 and out_ready=1 -> next cycle out_valid=1 with the same result; flags N=0 Z=0 C=0 V=0.
REQ-034 Push 64'h0 with set_flags=1, then 64'hFFFFFFFFFFFFFFFF with set_flags=0 -> Z=1 and N=0 after both pushes (the second push leaves flags untouched).
REQ-035 out_ready=0 with three back-to-back pushes A, B, C -> A and B accepted and in_ready=0 on the third; C held; after out_ready=1, outputs appear in order A, B, C with no loss or duplication.
REQ-036 Occupancy 1 with simultaneous push and pop for 10 cycles -> occupancy stays 1, out_valid stays 1, order preserved.
REQ-037 Occupancy 2 with flags Z=1, then flush=1 together with a set-flags push of 64'h8000000000000000 -> out_valid=0 next cycle, Z=1 and N=0 retained.
REQ-038 Occupancy 2, then reset=0 for one cycle -> out_valid=0, all flags 0, in_ready=1 the cycle after release.
